// File: rtl/layer_input_streamer.sv
// Buffers one input vector per layer and replays it on the shared neuron bus.
// Define LAYER_STREAMER_DOUBLE_BUF_EN for ping-pong banks (load during stream).
module layer_input_streamer #(
    parameter int numWeight = 784,
    parameter int dataWidth = 16,
    parameter int padCycles = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [dataWidth-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 freeze,
    output logic [dataWidth-1:0] myinput,
    output logic                 layer_done,
    output logic                 busy
);

`ifdef LAYER_STREAMER_DOUBLE_BUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int PW = (numWeight > 1) ? $clog2(numWeight) : 1;
    localparam int CW = $clog2(padCycles + 1);
    localparam logic [PW-1:0] LAST = PW'(numWeight - 1);
    localparam logic [CW-1:0] PLAST = CW'(padCycles - 1);

    typedef enum logic [1:0] {LOAD, STREAM, PAD, DONE} state_t;

    state_t state, state_n;
    logic [dataWidth-1:0] mem [NB][numWeight];
    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [CW-1:0] pad_cnt, pad_cnt_n;
    logic wr_bank, wr_bank_n;
    logic rd_bank, rd_bank_n;
    logic [NB-1:0] full, full_n;
    logic wr_en, wr_last;
    logic freeze_n;
    logic [dataWidth-1:0] myinput_n;

    function automatic logic flip(input logic b);
        return (NB == 2) ? ~b : 1'b0;
    endfunction

    // A bank stays full from its last accepted word until its DONE cycle.
    assign in_ready   = ~full[wr_bank];
    assign wr_en      = in_valid & in_ready;
    assign wr_last    = wr_en & (wr_ptr == LAST);
    assign layer_done = (state == DONE);
    assign busy       = (state != LOAD);

    always_comb begin
        state_n   = state;
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        pad_cnt_n = pad_cnt;
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        full_n    = full;
        if (wr_en) begin
            wr_ptr_n = wr_last ? '0 : wr_ptr + 1'b1;
            if (wr_last) begin
                full_n[wr_bank] = 1'b1;
                wr_bank_n       = flip(wr_bank);
            end
        end
        unique case (state)
            LOAD: begin
                if (full_n[rd_bank]) begin
                    state_n  = STREAM;
                    rd_ptr_n = '0;
                end
            end
            STREAM: begin
                if (rd_ptr == LAST) begin
                    state_n   = PAD;
                    rd_ptr_n  = '0;
                    pad_cnt_n = '0;
                end else begin
                    rd_ptr_n = rd_ptr + 1'b1;
                end
            end
            PAD: begin
                if (pad_cnt == PLAST) state_n = DONE;
                else pad_cnt_n = pad_cnt + 1'b1;
            end
            DONE: begin
                full_n[rd_bank] = 1'b0;
                rd_bank_n       = flip(rd_bank);
                rd_ptr_n        = '0;
                state_n         = full_n[rd_bank_n] ? STREAM : LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    // Bypass covers the word written on the same edge it is first replayed.
    always_comb begin
        freeze_n  = ~((state_n == STREAM) || (state_n == PAD));
        myinput_n = '0;
        if (state_n == STREAM) begin
            if (wr_en && (wr_bank == rd_bank_n) && (wr_ptr == rd_ptr_n))
                myinput_n = in_data;
            else
                myinput_n = mem[rd_bank_n][rd_ptr_n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pad_cnt <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
            freeze  <= 1'b1;
            myinput <= '0;
        end else begin
            state   <= state_n;
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            pad_cnt <= pad_cnt_n;
            wr_bank <= wr_bank_n;
            rd_bank <= rd_bank_n;
            full    <= full_n;
            freeze  <= freeze_n;
            myinput <= myinput_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_ptr] <= in_data;
    end

endmodule

// File: doc/layer_input_streamer.md
# layer_input_streamer

Feeds one neuron layer with its input vector.
- Accepts `numWeight` input words from the upstream layer or host over a valid/ready stream and buffers them.
- Replays the buffered words one per clock on the shared `myinput`/`freeze` bus that every neuron of the layer consumes.
- Pulses `layer_done` once the neurons' accumulations (including the bias add) are complete and their outputs are stable.

## Interface
Parameters:
- `numWeight`, 784, words per input vector (≥1); buffer depth per bank
- `dataWidth`, 16, word width, two's complement, stored and replayed verbatim
- `padCycles`, 2, cycles `freeze` stays low after the last word to cover the neuron multiply pipeline and bias add (≥1)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_data` in `dataWidth`: input word
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: word accepted on a cycle with `in_valid & in_ready`
- `freeze` out 1: to neurons; low = accumulate
- `myinput` out `dataWidth`: to neurons; current vector element
- `layer_done` out 1: single-cycle pulse, layer outputs valid
- `busy` out 1: high in STREAM, PAD, DONE

## Operation
- States:
  - LOAD: `wr_ptr` counts accepted words 0..numWeight-1.
  - STREAM: `rd_ptr` 0..numWeight-1, `freeze`=0, `myinput`=buffer[rd_ptr].
  - PAD: `padCycles` cycles, `freeze`=0, `myinput`=0.
  - DONE: one cycle, `freeze`=1, `layer_done`=1.
- Transitions:
  - LOAD→STREAM on acceptance of word numWeight-1.
  - STREAM→PAD after element numWeight-1 has been driven.
  - PAD→DONE after `padCycles`.
  - DONE→LOAD.
- Output registers: `freeze` and `myinput` are registered; `myinput`=0 whenever `freeze`=1.
- Flow control: `in_valid` while `in_ready`=0 is ignored; the source must hold `in_data`.
- Counters: `wr_ptr` and `rd_ptr` wrap to 0 at numWeight; the pad counter is sized `$clog2(padCycles+1)`.
- Reset:
  - Asynchronous assertion, at any time including mid-STREAM, immediately forces `freeze`=1, `myinput`=0, `layer_done`=0, `busy`=0, `in_ready`=1, state LOAD, and all pointers to 0.
  - Any partial load is discarded; buffer contents are don't-care.
- `numWeight`=1 is legal: STREAM lasts exactly one cycle.

## Timing
- Let L be the cycle in which the last word is accepted.
- L+1 .. L+numWeight: `freeze`=0, `myinput`=x[k] at cycle L+1+k.
- L+numWeight+1 .. L+numWeight+padCycles: `freeze`=0, `myinput`=0.
- L+numWeight+padCycles+1: `freeze`=1, `layer_done`=1 (DONE).
- Total latency from last accepted word to `layer_done` is numWeight+padCycles+1 cycles.
- Between consecutive vectors, `freeze` is high for at least one cycle so that each neuron restarts its accumulator.
- Without double buffering, `in_ready`=0 from L+1 through DONE inclusive and returns to 1 the cycle after DONE.

## Configuration
Macro `LAYER_STREAMER_DOUBLE_BUF_EN`.

Defined:
- Two buffer banks in ping-pong. Loading targets the bank not being streamed.
- `in_ready`=1 unless both banks hold complete, unstreamed or streaming vectors.
- A bank that completes while the other bank streams waits. Its STREAM starts the cycle after DONE, giving exactly one `freeze`=1 cycle between vectors.
- A bank that completes while the streamer is idle starts at L+1 as in single-buffer mode.
- Reset invalidates both banks.

Undefined:
- Single bank, timing as above.
- No loading during STREAM/PAD/DONE.

## Test plan
- Reset, then numWeight=4, padCycles=2, load 1,2,3,4 back-to-back (L=cycle 4) -> `myinput`=1,2,3,4 at cycles 5–8 with `freeze`=0; `myinput`=0 at cycles 9–10 with `freeze`=0; `layer_done`=1 and `freeze`=1 at cycle 11.
- Load with `in_valid` toggling every other cycle and words 0x8000, 0x7FFF, 0xFFFF, 0x0001 -> all four replayed bit-exact; `wr_ptr` advances only on handshakes.
- Single buffer: assert `in_valid` during STREAM -> `in_ready`=0, no word consumed until the cycle after `layer_done`.
- Assert `rst_n`=0 at the midpoint of STREAM -> same cycle `freeze`=1, `myinput`=0, `busy`=0; a fresh load afterwards streams correctly from x[0].
- `LAYER_STREAMER_DOUBLE_BUF_EN` defined: load vector B continuously during A's stream -> B's STREAM begins exactly one cycle after A's `layer_done`, with exactly one `freeze`=1 cycle between them.
- numWeight=1, padCycles=1: load 0x0005 at L -> `myinput`=5 at L+1, 0 at L+2, `layer_done` at L+3.
